rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the single write port of the 32x32 register file between two writeback requesters: req0 (ALU result) and req1 (load return). Fair round-robin arbitration uses a valid/ready handshake. The winning beat is registered onto the register-file write port (reg_write/waddr/wdata). Per-requester saturating grant counters provide performance visibility.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, write data width
CNT_W, 16, width of each grant counter

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
hold  input  1  1 = grant nothing this cycle (pipeline stall)
req0_valid  input  1  requester 0 has a write beat
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req0_ready  output  1  requester 0 beat accepted this cycle
req1_valid  input  1  requester 1 has a write beat
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
req1_ready  output  1  requester 1 beat accepted this cycle
rf_reg_write  output  1  to reg_file reg_write
rf_waddr  output  ADDR_W  to reg_file waddr
rf_wdata  output  DATA_W  to reg_file wdata
grant_cnt0  output  CNT_W  accepted beats from requester 0, saturating
grant_cnt1  output  CNT_W  accepted beats from requester 1, saturating

Behaviour:
- Clock is clk; reset is reset_n, asynchronous and active-low.
- Reset values: rf_reg_write=0, rf_waddr=0, rf_wdata=0, grant_cnt0=0, grant_cnt1=0, priority pointer=req0.
- reqX_ready is combinational from the valids, hold and the pointer. At most one ready is high per cycle. Ready never asserts without the matching valid.
- Handshake: a beat transfers on a rising edge where reqX_valid && reqX_ready. A requester must hold valid/addr/data stable until accepted.
- Arbitration with hold=0:
  - Only one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
  - Pointer update: after a grant to i, the pointer moves to the other requester. With no grant, the pointer is unchanged.
  - Consequence: continuous dual requests alternate 0,1,0,1...
- hold=1: both readies are 0, the pointer is frozen, and counters do not change. The output stage still drains its current beat, then presents rf_reg_write=0.
- Latency: a beat accepted at edge N appears on rf_* during cycle N..N+1. The register file captures it at edge N+1. Result: 2 edges from acceptance to the data being readable at rdata.
- Output stage is a single register with no buffering; the arbiter accepts at most 1 beat per cycle, matching the single write port. A cycle with no accept drives rf_reg_write=0 on the next cycle. rf_waddr/rf_wdata hold their last values when idle.
- Address 0: the beat is accepted normally (ready, counter increments), but rf_reg_write stays 0 for it. x0 is never written.
- Same address from both requesters in back-to-back beats: both writes are issued in grant order, so the last granted value wins in the register file.
- Counters increment by 1 per accepted beat and saturate at 2^CNT_W-1; they never wrap.
- Reset mid-operation: the output stage clears asynchronously, and an accepted-but-unwritten beat is dropped. Requesters must reissue after reset.

Test Plan:
- Reset: reset_n=0 with both valid → readies 0, rf_reg_write=0, counters 0. Release reset with req0 valid (addr 21, data 0x0F0F0F0F) → req0_ready=1 the same cycle, rf_reg_write=1, rf_waddr=21, rf_wdata=0x0F0F0F0F next cycle, reg_file x21 reads 0x0F0F0F0F afterwards.
- Contention: both valid for 6 cycles (req0 addr 3, req1 addr 4) → grants alternate 0,1,0,1,0,1. grant_cnt0=3, grant_cnt1=3. Each output beat carries the matching addr/data.
- x0 write: req1 addr 0, data 0x222222FF → req1_ready=1, grant_cnt1 increments, rf_reg_write stays 0, x0 still reads 0.
- Hold: both valid, hold=1 for 4 cycles → readies 0, rf_reg_write=0 after the drain cycle, counters and pointer frozen. On release, the pointer's requester is granted first.
- Same address: req0 writes 0xAAAAAAAA to x5, then req1 writes 0x55555555 to x5 → both beats are issued in that order, and x5 reads 0x55555555.
- Saturation (CNT_W=4): 20 req0 beats → grant_cnt0=15. Async reset mid-stream while rf_reg_write=1 → rf_reg_write drops immediately without waiting for clk.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register-file write port
// between ALU writeback (req0) and load return (req1).
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   hold                   stall: grant nothing, freeze pointer/counters
//   reqN_valid/addr/data   writeback beat from requester N
//   reqN_ready             beat N accepted this cycle (combinational)
//   rf_reg_write/waddr/wdata  registered register-file write port
//   grant_cnt0/1           saturating accepted-beat counters

module rf_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  // ptr = 0: req0 wins a tie; ptr = 1: req1 wins a tie
  logic              ptr;
  logic              gnt0;
  logic              gnt1;
  logic              wr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  // No grants while in reset: the output stage could not capture them.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && !hold) begin
      gnt0 = req0_valid && (!req1_valid || !ptr);
      gnt1 = req1_valid && (!req0_valid ||  ptr);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // x0 beats are accepted but never reach the write enable.
  always_comb begin
    wr_nxt   = 1'b0;
    addr_nxt = rf_waddr;
    data_nxt = rf_wdata;
    unique case (1'b1)
      gnt0: begin
        wr_nxt   = |req0_addr;
        addr_nxt = req0_addr;
        data_nxt = req0_data;
      end
      gnt1: begin
        wr_nxt   = |req1_addr;
        addr_nxt = req1_addr;
        data_nxt = req1_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_reg_write <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      rf_reg_write <= wr_nxt;
      rf_waddr     <= addr_nxt;
      rf_wdata     <= data_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (gnt0 && (grant_cnt0 != '1))
        grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt1 && (grant_cnt1 != '1))
        grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of the register-file write
// arbiter, with a small register-file model fed by the rf_* port.

module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hold;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rf_reg_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] grant_cnt0;
  logic [CW-1:0] grant_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] rf [32];

  rf_write_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hold        (hold),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .rf_reg_write(rf_reg_write),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .grant_cnt0  (grant_cnt0),
    .grant_cnt1  (grant_cnt1)
  );

  always #5 clk = ~clk;

  // register file: x0 hard-wired to zero
  always @(posedge clk)
    if (rf_reg_write && rf_waddr != 0)
      rf[rf_waddr] <= rf_wdata;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag,
                     input logic e0,
                     input logic e1);
    @(negedge clk);
    chk({tag, "_rdy0"}, 32'(req0_ready), 32'(e0));
    chk({tag, "_rdy1"}, 32'(req1_ready), 32'(e1));
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    hold = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    foreach (rf[i]) rf[i] = '0;
    hold       = 1'b0;
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 5'd1;
    req0_data  = 32'h1;
    req1_valid = 1'b1;
    req1_addr  = 5'd2;
    req1_data  = 32'h2;

    // reset with both valid
    #3;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_wr", 32'(rf_reg_write), 32'd0);
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'd0);

    // first beat after reset release
    reset_n    = 1'b1;
    req1_valid = 1'b0;
    req0_addr  = 5'd21;
    req0_data  = 32'h0F0F0F0F;
    #1;
    chk("first_rdy0", 32'(req0_ready), 32'd1);
    chk("first_rdy1", 32'(req1_ready), 32'd0);
    tick();
    idle();
    chk("first_wr", 32'(rf_reg_write), 32'd1);
    chk("first_addr", 32'(rf_waddr), 32'd21);
    chk("first_data", rf_wdata, 32'h0F0F0F0F);
    tick();
    chk("first_idle_wr", 32'(rf_reg_write), 32'd0);
    chk("first_hold_addr", 32'(rf_waddr), 32'd21);
    chk("x21", rf[21], 32'h0F0F0F0F);
    chk("first_cnt0", 32'(grant_cnt0), 32'd1);

    // contention: alternation starting at req0
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 5'd3;
    req0_data  = 32'hA0000003;
    req1_valid = 1'b1;
    req1_addr  = 5'd4;
    req1_data  = 32'hB0000004;
    for (int i = 0; i < 6; i++) begin
      rdy("cont", (i % 2) == 0, (i % 2) == 1);
      tick();
      chk("cont_wr", 32'(rf_reg_write), 32'd1);
      chk("cont_addr", 32'(rf_waddr),
          (i % 2) ? 32'd4 : 32'd3);
      chk("cont_data", rf_wdata,
          (i % 2) ? 32'hB0000004 : 32'hA0000003);
    end
    idle();
    chk("cont_cnt0", 32'(grant_cnt0), 32'd3);
    chk("cont_cnt1", 32'(grant_cnt1), 32'd3);

    // x0 write: accepted, never issued
    req1_valid = 1'b1;
    req1_addr  = 5'd0;
    req1_data  = 32'h222222FF;
    rdy("x0", 1'b0, 1'b1);
    tick();
    idle();
    chk("x0_wr", 32'(rf_reg_write), 32'd0);
    chk("x0_cnt1", 32'(grant_cnt1), 32'd4);
    tick();
    chk("x0_read", rf[0], 32'd0);
    chk("x3_read", rf[3], 32'hA0000003);
    chk("x4_read", rf[4], 32'hB0000004);

    // hold right after a req0 grant: drain, freeze
    req0_valid = 1'b1;
    req0_addr  = 5'd6;
    req0_data  = 32'h66;
    rdy("pre_hold", 1'b1, 1'b0);
    tick();
    req1_valid = 1'b1;
    req1_addr  = 5'd8;
    req1_data  = 32'h88;
    req0_addr  = 5'd7;
    req0_data  = 32'h77;
    hold = 1'b1;
    chk("drain_wr", 32'(rf_reg_write), 32'd1);
    chk("drain_addr", 32'(rf_waddr), 32'd6);
    for (int i = 0; i < 4; i++) begin
      rdy("hold", 1'b0, 1'b0);
      tick();
      chk("hold_wr", 32'(rf_reg_write), 32'd0);
    end
    chk("hold_cnt0", 32'(grant_cnt0), 32'd4);
    chk("hold_cnt1", 32'(grant_cnt1), 32'd4);
    hold = 1'b0;
    rdy("release", 1'b0, 1'b1);
    tick();
    idle();
    chk("release_wr", 32'(rf_reg_write), 32'd1);
    chk("release_addr", 32'(rf_waddr), 32'd8);
    chk("release_data", rf_wdata, 32'h88);
    chk("release_cnt1", 32'(grant_cnt1), 32'd5);

    // same address, req0 then req1
    req0_valid = 1'b1;
    req0_addr  = 5'd5;
    req0_data  = 32'hAAAAAAAA;
    rdy("same0", 1'b1, 1'b0);
    tick();
    idle();
    chk("same0_data", rf_wdata, 32'hAAAAAAAA);
    req1_valid = 1'b1;
    req1_addr  = 5'd5;
    req1_data  = 32'h55555555;
    rdy("same1", 1'b0, 1'b1);
    tick();
    idle();
    chk("same1_wr", 32'(rf_reg_write), 32'd1);
    chk("same1_data", rf_wdata, 32'h55555555);
    tick();
    chk("x5_read", rf[5], 32'h55555555);
    chk("x8_read", rf[8], 32'h88);
    chk("same_cnt0", 32'(grant_cnt0), 32'd5);
    chk("same_cnt1", 32'(grant_cnt1), 32'd6);

    // saturation with 4-bit counters
    do_reset();
    req0_valid = 1'b1;
    req0_addr  = 5'd9;
    req0_data  = 32'h99;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_cnt14", 32'(grant_cnt0), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt0", 32'(grant_cnt0), 32'd15);
    chk("sat_cnt1", 32'(grant_cnt1), 32'd0);
    chk("sat_wr", 32'(rf_reg_write), 32'd1);

    // async reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_wr", 32'(rf_reg_write), 32'd0);
    chk("async_cnt0", 32'(grant_cnt0), 32'd0);
    chk("async_addr", 32'(rf_waddr), 32'd0);
    chk("async_rdy0", 32'(req0_ready), 32'd0);
    idle();
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
